// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

endpackage

// File: rtl/lsu_align.sv
// Lane merge for sub-word stores and lane extract with sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  lane_i,
    input  logic        uns_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [31:0] shifted_b;
    logic [31:0] shifted_h;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign bsh       = {lane_i, 3'b000};
    assign hsh       = {lane_i[1], 4'b0000};
    assign shifted_b = word_i >> bsh;
    assign shifted_h = word_i >> hsh;
    assign byte_v    = shifted_b[7:0];
    assign half_v    = shifted_h[15:0];

    always_comb begin
        merged_o = wdata_i;
        rdata_o  = word_i;
        case (size_i)
            SZ_BYTE: begin
                merged_o = (word_i & ~(BYTE_MASK << bsh)) | ((wdata_i & BYTE_MASK) << bsh);
                rdata_o  = uns_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                merged_o = (word_i & ~(HALF_MASK << hsh)) | ((wdata_i & HALF_MASK) << hsh);
                rdata_o  = uns_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                merged_o = wdata_i;
                rdata_o  = word_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: request FSM, request/capture registers and access checks.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        memRW,
    output logic [31:0] addr,
    output logic [31:0] DataW,
    input  logic [31:0] DataR
);

    state_e      state_q, state_d;
    logic        we_q, uns_q, err_q;
    size_e       size_q;
    logic [1:0]  lane_q;
    logic [29:0] widx_q;
    logic [31:0] wdata_q, word_q;

    logic        accept, misalign, oor, illegal, req_err;
    logic [31:0] merged, ext_rdata;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign misalign = (req_size == SZ_HALF && req_addr[0]) ||
                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign oor      = (req_addr[31:2] >> DEPTH_LOG2) != 30'h0;
    assign illegal  = (req_size == SZ_ILL);
    assign req_err  = misalign || oor || illegal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                   state_d = ST_RESP;
                    else if (!req_we)              state_d = ST_READ;
                    else if (req_size == SZ_WORD)  state_d = ST_WRITE;
                    else                           state_d = ST_READ;
                end
            end
            ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            lane_q  <= 2'b00;
            widx_q  <= 30'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                size_q  <= size_e'(req_size);
                lane_q  <= req_addr[1:0];
                widx_q  <= req_addr[31:2];
                wdata_q <= req_wdata;
            end
            if (state_q == ST_READ)
                word_q <= DataR;
        end
    end

    lsu_align u_align (
        .size_i   (size_q),
        .lane_i   (lane_q),
        .uns_i    (uns_q),
        .word_i   (word_q),
        .wdata_i  (wdata_q),
        .merged_o (merged),
        .rdata_o  (ext_rdata)
    );

    // memRW decodes straight from the state register so an async reset drops it at once.
    assign memRW     = (state_q == ST_WRITE);
    assign addr      = {2'b00, widx_q};
    assign DataW     = merged;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ext_rdata : 32'h0;

endmodule
